// File: rtl/mm2s_rd_arbiter_if.sv
// Bundle of requester-side and read-engine-side signals for the 2:1 MM2S read arbiter.
// Requester k owns slice k of every per-requester bus.
interface mm2s_rd_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 42,
    parameter int AXI_ID_WIDTH   = 1,
    parameter int RX_SIZE_WIDTH  = 10
);
    // requester side
    logic [1:0]                  i_req_addr_req;
    logic [2*AXI_ADDR_WIDTH-1:0] i_req_addr;
    logic [2*RX_SIZE_WIDTH-1:0]  i_req_size;
    logic [2*AXI_ID_WIDTH-1:0]   i_req_id;
    logic [1:0]                  i_req_data_ready;
    logic [1:0]                  o_req_addr_ready;
    logic [1:0]                  o_req_data_req;
    logic [1:0]                  o_req_done;
    // shared read engine
    logic                        o_mm2s_addr_req;
    logic [AXI_ADDR_WIDTH-1:0]   o_mm2s_addr;
    logic [RX_SIZE_WIDTH-1:0]    o_mm2s_size;
    logic [AXI_ID_WIDTH-1:0]     o_mm2s_req_id;
    logic                        i_mm2s_addr_ready;
    logic                        i_mm2s_done;
    logic                        i_mm2s_data_req;
    logic                        o_mm2s_data_ready;
    // status
    logic [1:0]                  o_grant;
    logic                        o_busy;
    logic                        o_timeout;
    logic                        o_timeout_id;

    // arbiter view
    modport slave (
        input  i_req_addr_req, i_req_addr, i_req_size, i_req_id, i_req_data_ready,
        input  i_mm2s_addr_ready, i_mm2s_done, i_mm2s_data_req,
        output o_req_addr_ready, o_req_data_req, o_req_done,
        output o_mm2s_addr_req, o_mm2s_addr, o_mm2s_size, o_mm2s_req_id, o_mm2s_data_ready,
        output o_grant, o_busy, o_timeout, o_timeout_id
    );

    // environment view (requesters + engine)
    modport master (
        output i_req_addr_req, i_req_addr, i_req_size, i_req_id, i_req_data_ready,
        output i_mm2s_addr_ready, i_mm2s_done, i_mm2s_data_req,
        input  o_req_addr_ready, o_req_data_req, o_req_done,
        input  o_mm2s_addr_req, o_mm2s_addr, o_mm2s_size, o_mm2s_req_id, o_mm2s_data_ready,
        input  o_grant, o_busy, o_timeout, o_timeout_id
    );
endinterface

// File: rtl/mm2s_rd_arbiter.sv
// Round-robin 2:1 arbiter sharing one MM2S read engine between two requesters.
// One owner at a time: address phase, data phase, one release cycle, then idle.
// Optional data-phase watchdog enabled by defining MM2S_ARB_TIMEOUT_EN.
module mm2s_rd_arbiter #(
    parameter int AXI_ADDR_WIDTH = 42,
    parameter int AXI_ID_WIDTH   = 1,
    parameter int RX_SIZE_WIDTH  = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    mm2s_rd_arbiter_if.slave    bus
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int IW = AXI_ID_WIDTH;
    localparam int SW = RX_SIZE_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RELEASE} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;           // index of the current owner
    logic   last_grant_q, last_grant_d; // index of the last requester to finish
    logic   done_q;                     // previous-cycle i_mm2s_done
    logic   done_edge;
    logic   to_hit;                     // watchdog expiry this cycle

    logic          own_req;
    logic          own_data_ready;
    logic [AW-1:0] own_addr;
    logic [SW-1:0] own_size;
    logic [IW-1:0] own_id;

    assign done_edge      = bus.i_mm2s_done & ~done_q;
    assign own_req        = owner_q ? bus.i_req_addr_req[1]   : bus.i_req_addr_req[0];
    assign own_data_ready = owner_q ? bus.i_req_data_ready[1] : bus.i_req_data_ready[0];
    assign own_addr       = owner_q ? bus.i_req_addr[2*AW-1:AW] : bus.i_req_addr[AW-1:0];
    assign own_size       = owner_q ? bus.i_req_size[2*SW-1:SW] : bus.i_req_size[SW-1:0];
    assign own_id         = owner_q ? bus.i_req_id[2*IW-1:IW]   : bus.i_req_id[IW-1:0];

    // state, ownership and done-edge registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first contest
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            done_q       <= bus.i_mm2s_done;
        end
    end

    // next-state: round-robin pick in idle, handshake/abort in addr, done edge or watchdog in data
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.i_req_addr_req) begin
                    // on contention the requester that did not go last wins
                    owner_d = (&bus.i_req_addr_req) ? ~last_grant_q : bus.i_req_addr_req[1];
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                // the handshake wins over a same-cycle request drop
                if (bus.i_mm2s_addr_ready)
                    state_d = S_DATA;
                else if (!own_req)
                    state_d = S_IDLE;
            end
            S_DATA: begin
                if (done_edge || to_hit)
                    state_d = S_RELEASE;
            end
            S_RELEASE: begin
                last_grant_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // route the owner's signals; everything not owned stays at 0
    always_comb begin
        bus.o_req_addr_ready  = 2'b00;
        bus.o_req_data_req    = 2'b00;
        bus.o_req_done        = 2'b00;
        bus.o_mm2s_addr_req   = 1'b0;
        bus.o_mm2s_addr       = '0;
        bus.o_mm2s_size       = '0;
        bus.o_mm2s_req_id     = '0;
        bus.o_mm2s_data_ready = 1'b0;
        bus.o_grant           = 2'b00;
        bus.o_busy            = (state_q != S_IDLE);
        case (state_q)
            S_ADDR: begin
                bus.o_grant[owner_q]          = 1'b1;
                bus.o_mm2s_addr_req           = 1'b1;
                bus.o_mm2s_addr               = own_addr;
                bus.o_mm2s_size               = own_size;
                bus.o_mm2s_req_id             = own_id;
                bus.o_req_addr_ready[owner_q] = bus.i_mm2s_addr_ready;
            end
            S_DATA: begin
                bus.o_grant[owner_q]        = 1'b1;
                bus.o_mm2s_data_ready       = own_data_ready;
                bus.o_req_data_req[owner_q] = bus.i_mm2s_data_req;
                bus.o_req_done[owner_q]     = bus.i_mm2s_done;
            end
            default: ;
        endcase
    end

`ifdef MM2S_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             timeout_id_q, timeout_id_d;

    // expiry on the TIMEOUT_CYCLES-th data cycle; a real done edge takes precedence
    assign to_hit = (state_q == S_DATA) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !done_edge;

    // watchdog: count data-phase cycles, latch the stuck owner on expiry
    always_comb begin
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        timeout_id_d = timeout_id_q;
        if (state_q == S_ADDR)
            cnt_d = '0;             // so the first data cycle sees 0
        else if (state_q == S_DATA)
            cnt_d = cnt_q + 1'b1;
        if (to_hit) begin
            timeout_d    = 1'b1;
            timeout_id_d = owner_q;
        end
    end

    // watchdog registers; the flag is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    assign bus.o_timeout    = timeout_q;
    assign bus.o_timeout_id = timeout_id_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign to_hit             = 1'b0;
    assign bus.o_timeout      = 1'b0;
    assign bus.o_timeout_id   = 1'b0;
`endif

endmodule

// File: tb/tb_mm2s_rd_arbiter.sv
// Self-checking bench for mm2s_rd_arbiter: vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_mm2s_rd_arbiter;
    localparam int AW = 42;
    localparam int IW = 1;
    localparam int SW = 10;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mm2s_rd_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .RX_SIZE_WIDTH(SW)) bus ();

    mm2s_rd_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .RX_SIZE_WIDTH(SW),
                      .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [1:0]    ardy, dreq, done;
        logic          mreq;
        logic [AW-1:0] addr;
        logic [SW-1:0] size;
        logic [IW-1:0] id;
        logic          dready;
        logic [1:0]    grant;
        logic          busy, to, toid;
    } outs_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t get_outs();
        outs_t o;
        o.ardy   = bus.o_req_addr_ready;
        o.dreq   = bus.o_req_data_req;
        o.done   = bus.o_req_done;
        o.mreq   = bus.o_mm2s_addr_req;
        o.addr   = bus.o_mm2s_addr;
        o.size   = bus.o_mm2s_size;
        o.id     = bus.o_mm2s_req_id;
        o.dready = bus.o_mm2s_data_ready;
        o.grant  = bus.o_grant;
        o.busy   = bus.o_busy;
        o.to     = bus.o_timeout;
        o.toid   = bus.o_timeout_id;
        return o;
    endfunction

    task automatic clear_inputs();
        bus.i_req_addr_req    = 2'b00;
        bus.i_req_data_ready  = 2'b00;
        bus.i_mm2s_addr_ready = 1'b0;
        bus.i_mm2s_done       = 1'b0;
        bus.i_mm2s_data_req   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    // bounded wait for the address phase
    task automatic wait_addr(input string nm);
        int n = 0;
        while (!bus.o_mm2s_addr_req && n < 20) begin
            cyc();
            n++;
        end
        chk({nm, "_wait"}, 128'(n < 20), 128'(1));
    endtask

    // ---------------- reference model (transaction level) ----------------
    localparam int PH_IDLE = 0, PH_ADDR = 1, PH_DATA = 2, PH_REL = 3;
    int   m_ph, m_own, m_last, m_cnt;
    logic m_prev_done, m_to, m_toid;

    task automatic model_reset();
        m_ph = PH_IDLE; m_own = 0; m_last = 1; m_cnt = 0;
        m_prev_done = 1'b0; m_to = 1'b0; m_toid = 1'b0;
    endtask

    function automatic outs_t model_outs();
        outs_t o = '0;
        int k = m_own;
        o.busy = (m_ph != PH_IDLE);
        o.to   = m_to;
        o.toid = m_toid;
        if (m_ph == PH_ADDR) begin
            o.grant[k] = 1'b1;
            o.mreq     = 1'b1;
            o.addr     = bus.i_req_addr[k*AW +: AW];
            o.size     = bus.i_req_size[k*SW +: SW];
            o.id       = bus.i_req_id[k*IW +: IW];
            o.ardy[k]  = bus.i_mm2s_addr_ready;
        end
        if (m_ph == PH_DATA) begin
            o.grant[k] = 1'b1;
            o.dready   = bus.i_req_data_ready[k];
            o.dreq[k]  = bus.i_mm2s_data_req;
            o.done[k]  = bus.i_mm2s_done;
        end
        return o;
    endfunction

    // advance the model across one clock edge with the current inputs
    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        case (m_ph)
            PH_IDLE: if (bus.i_req_addr_req != 2'b00) begin
                if (bus.i_req_addr_req == 2'b11) m_own = 1 - m_last;
                else                             m_own = bus.i_req_addr_req[1] ? 1 : 0;
                m_ph = PH_ADDR;
            end
            PH_ADDR: begin
                if (bus.i_mm2s_addr_ready) begin m_ph = PH_DATA; m_cnt = 0; end
                else if (!bus.i_req_addr_req[m_own]) m_ph = PH_IDLE;
            end
            PH_DATA: begin
                m_cnt++;
                if (bus.i_mm2s_done && !m_prev_done) m_ph = PH_REL;
`ifdef MM2S_ARB_TIMEOUT_EN
                else if (m_cnt == TO) begin
                    m_ph = PH_REL; m_to = 1'b1; m_toid = m_own[0];
                end
`endif
            end
            default: begin m_last = m_own; m_ph = PH_IDLE; end
        endcase
        m_prev_done = bus.i_mm2s_done;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] req;
        logic       ardy, done, dreq;
        logic [1:0] e_grant;
        logic       e_busy;
        logic [1:0] e_ardy, e_dreq, e_done;
        logic       e_mreq, e_drdy;
    } vec_t;
    vec_t vt[8];

    initial begin
        outs_t o;
        reset = 1'b1;
        bus.i_req_addr = {42'h0_0000_2000, 42'h0_0000_1000};
        bus.i_req_size = {10'd64, 10'd256};
        bus.i_req_id   = 2'b10;
        clear_inputs();

        vt[0] = '{2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0};
        vt[1] = '{2'b01, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 1, 0};
        vt[2] = '{2'b01, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 1, 0};
        vt[3] = '{2'b01, 1, 0, 0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 1, 0};
        vt[4] = '{2'b00, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 2'b00, 0, 1};
        vt[5] = '{2'b00, 0, 1, 1, 2'b01, 1, 2'b00, 2'b01, 2'b01, 0, 1};
        vt[6] = '{2'b00, 0, 1, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0};
        vt[7] = '{2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0};

        // reset state
        do_reset();
        chk("reset_outs", 128'(get_outs()), 128'(0));

        // single burst from requester 0
        bus.i_req_data_ready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            bus.i_req_addr_req    = vt[i].req;
            bus.i_mm2s_addr_ready = vt[i].ardy;
            bus.i_mm2s_done       = vt[i].done;
            bus.i_mm2s_data_req   = vt[i].dreq;
            #1;
            chk($sformatf("vec%0d", i),
                128'({bus.o_grant, bus.o_busy, bus.o_req_addr_ready, bus.o_req_data_req,
                      bus.o_req_done, bus.o_mm2s_addr_req, bus.o_mm2s_data_ready}),
                128'({vt[i].e_grant, vt[i].e_busy, vt[i].e_ardy, vt[i].e_dreq,
                      vt[i].e_done, vt[i].e_mreq, vt[i].e_drdy}));
            if (vt[i].e_mreq)
                chk($sformatf("vec%0d_cmd", i),
                    128'({bus.o_mm2s_addr, bus.o_mm2s_size, bus.o_mm2s_req_id}),
                    128'({42'h0_0000_1000, 10'd256, 1'b0}));
            cyc();
        end

        // both requesters held: grants alternate 0,1,0,1
        do_reset();
        bus.i_req_addr_req = 2'b11;
        for (int b = 0; b < 4; b++) begin
            wait_addr($sformatf("alt%0d", b));
            chk($sformatf("alt%0d_grant", b), 128'(bus.o_grant), 128'((b % 2) ? 2'b10 : 2'b01));
            chk($sformatf("alt%0d_addr", b), 128'(bus.o_mm2s_addr),
                128'((b % 2) ? 42'h0_0000_2000 : 42'h0_0000_1000));
            bus.i_mm2s_addr_ready = 1'b1; cyc();
            bus.i_mm2s_addr_ready = 1'b0; bus.i_mm2s_done = 1'b1; cyc();
            bus.i_mm2s_done = 1'b0; cyc();
        end

        // requester 1 waits out requester 0's data phase and release
        do_reset();
        bus.i_req_addr_req = 2'b01;
        wait_addr("ovl");
        bus.i_mm2s_addr_ready = 1'b1; cyc();
        bus.i_mm2s_addr_ready = 1'b0;
        bus.i_req_addr_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            bus.i_mm2s_data_req = i[0];
            #1;
            chk($sformatf("ovl_dreq%0d", i), 128'({bus.o_grant, bus.o_req_data_req}),
                128'({2'b01, 1'b0, i[0]}));
            cyc();
        end
        bus.i_mm2s_data_req = 1'b0;
        bus.i_mm2s_done = 1'b1; #1;
        chk("ovl_done_routed", 128'(bus.o_req_done), 128'(2'b01));
        cyc();
        chk("ovl_release", 128'({bus.o_grant, bus.o_busy}), 128'({2'b00, 1'b1}));
        bus.i_mm2s_done = 1'b0; cyc();
        chk("ovl_idle", 128'({bus.o_grant, bus.o_busy}), 128'({2'b00, 1'b0}));
        cyc();
        chk("ovl_grant1", 128'({bus.o_grant, bus.o_mm2s_addr}), 128'({2'b10, 42'h0_0000_2000}));

        // done held high from the previous burst into the next data phase
        bus.i_mm2s_addr_ready = 1'b1; cyc();
        bus.i_mm2s_addr_ready = 1'b0;
        bus.i_req_addr_req = 2'b01;
        bus.i_mm2s_done = 1'b1; cyc();           // edge -> release of owner 1
        cyc();                                   // idle
        cyc();                                   // address phase, owner 0
        chk("held_grant0", 128'(bus.o_grant), 128'(2'b01));
        bus.i_mm2s_addr_ready = 1'b1; cyc();
        bus.i_mm2s_addr_ready = 1'b0; bus.i_req_addr_req = 2'b00;
        for (int i = 0; i < 5; i++) cyc();
        chk("held_no_release", 128'({bus.o_grant, bus.o_busy}), 128'({2'b01, 1'b1}));
        bus.i_mm2s_done = 1'b0; cyc();
        chk("held_low", 128'(bus.o_grant), 128'(2'b01));
        bus.i_mm2s_done = 1'b1; cyc();
        chk("held_release", 128'({bus.o_grant, bus.o_busy}), 128'({2'b00, 1'b1}));

        // watchdog: requester 1 never sees done
        do_reset();
        bus.i_req_addr_req = 2'b10;
        wait_addr("to");
        bus.i_mm2s_addr_ready = 1'b1; cyc();
        bus.i_mm2s_addr_ready = 1'b0; bus.i_req_addr_req = 2'b00;
        begin
            int n = 0;
            while (bus.o_grant != 2'b00 && n < 40) begin n++; cyc(); end
`ifdef MM2S_ARB_TIMEOUT_EN
            chk("to_cycles", 128'(n), 128'(TO));
            cyc();
            chk("to_flags", 128'({bus.o_timeout, bus.o_timeout_id}), 128'(2'b11));
`else
            chk("to_no_release", 128'(n), 128'(40));
            chk("to_flags", 128'({bus.o_timeout, bus.o_timeout_id}), 128'(2'b00));
            bus.i_mm2s_done = 1'b1; cyc();
            bus.i_mm2s_done = 1'b0; cyc();
`endif
        end

        // reset mid data phase: ownership dropped, no done routed
        bus.i_req_addr_req = 2'b01;
        wait_addr("rst");
        bus.i_mm2s_addr_ready = 1'b1; cyc();
        bus.i_mm2s_addr_ready = 1'b0;
        chk("rst_in_data", 128'(bus.o_grant), 128'(2'b01));
        reset = 1'b1; bus.i_mm2s_done = 1'b1; cyc();
        chk("rst_mid_burst", 128'(get_outs()), 128'(0));
        reset = 1'b0; clear_inputs();

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.i_req_addr_req    = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
            bus.i_req_addr        = {$urandom, $urandom, $urandom};
            bus.i_req_size        = 20'($urandom);
            bus.i_req_id          = 2'($urandom);
            bus.i_req_data_ready  = 2'($urandom);
            bus.i_mm2s_addr_ready = $urandom_range(0, 1);
            bus.i_mm2s_done       = ($urandom_range(0, 5) == 0);
            bus.i_mm2s_data_req   = $urandom_range(0, 1);
            #1;
            o = model_outs();
            chk($sformatf("rand%0d", i), 128'(get_outs()), 128'(o));
            model_step();
            cyc();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
